if_fetch_queue: RTL and testbench

Parametrised successor to the single-entry IF stage. It decouples instruction fetch from decode through a DEPTH-entry prefetch queue of {pc, instr} pairs. It talks to an external 1-cycle-latency instruction memory and hands instructions to ID over a valid/ready handshake. Redirects from EX (taken branch) and ID (jump) flush the queue and any in-flight fetch.

---
 rtl/if_fetch_queue_if.sv | 34 +++
 rtl/if_fetch_queue.sv | 128 ++++++++++++
 tb/tb_if_fetch_queue.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bundle: instruction-memory port, EX/ID redirects and the ID handshake.
// The master side is the fetch queue; the slave side is the surrounding pipeline/memory.
interface if_fetch_queue_if #(
  parameter int XLEN  = 64,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            o_im_req;
  logic [XLEN-1:0] o_im_addr;
  logic [ILEN-1:0] i_im_rdata;

  logic            i_ex_redirect;
  logic [XLEN-1:0] i_ex_target;
  logic            i_id_redirect;
  logic [XLEN-1:0] i_id_target;

  logic            o_if_valid;
  logic [ILEN-1:0] o_if_instr;
  logic [XLEN-1:0] o_if_pc;
  logic            i_id_ready;
  logic [CW-1:0]   o_q_count;

  modport master (
    output o_im_req, o_im_addr, o_if_valid, o_if_instr, o_if_pc, o_q_count,
    input  i_im_rdata, i_ex_redirect, i_ex_target, i_id_redirect, i_id_target, i_id_ready
  );

  modport slave (
    input  o_im_req, o_im_addr, o_if_valid, o_if_instr, o_if_pc, o_q_count,
    output i_im_rdata, i_ex_redirect, i_ex_target, i_id_redirect, i_id_target, i_id_ready
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch prefetch queue: DEPTH entries of {pc, instr} between a 1-cycle
// instruction memory and ID, flushed by EX/ID redirects.
module if_fetch_queue #(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic             clk,
  input logic             rst_n,
  if_fetch_queue_if.master bus
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CRW = CW + 1;

  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [ILEN-1:0] instr_mem_q [DEPTH];

  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] last_pc_q;
  logic [ILEN-1:0] last_instr_q;

  logic            valid;
  logic            pop;
  logic            push;
  logic            redirect;
  logic [XLEN-1:0] target;
  logic [CW:0]     credit;
  logic            issue;
  logic [XLEN-1:0] addr;

  assign valid    = (count_q != '0);
  assign redirect = bus.i_ex_redirect | bus.i_id_redirect;

  // EX outranks ID; targets are forced to word alignment.
  always_comb begin
    target = bus.i_ex_redirect ? bus.i_ex_target : bus.i_id_target;
    target = target & ~(XLEN'(3));
  end

  always_comb begin
    pop        = valid & bus.i_id_ready;
    push       = inflight_q & ~redirect;
    credit     = {1'b0, count_q} - CRW'(pop) + CRW'(inflight_q);
    issue      = 1'b0;
    addr       = fetch_pc_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (redirect) begin
      // The response landing this cycle belongs to the old path and is dropped.
      issue      = 1'b1;
      addr       = target;
      fetch_pc_d = target + XLEN'(4);
      req_pc_d   = target;
      inflight_d = 1'b1;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      // Only issue when the response is guaranteed a free slot on arrival.
      issue      = (credit < CRW'(DEPTH));
      inflight_d = issue;
      if (issue) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
        req_pc_d   = fetch_pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      inflight_q   <= 1'b0;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= '0;
      last_pc_q    <= '0;
      last_instr_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      if (valid) begin
        last_pc_q    <= pc_mem_q[rd_ptr_q];
        last_instr_q <= instr_mem_q[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
      instr_mem_q[wr_ptr_q] <= bus.i_im_rdata;
    end
  end

  // Request is held low while reset is asserted so the memory sees nothing then.
  assign bus.o_im_req   = issue & rst_n;
  assign bus.o_im_addr  = addr;
  assign bus.o_if_valid = valid;
  assign bus.o_if_pc    = valid ? pc_mem_q[rd_ptr_q]    : last_pc_q;
  assign bus.o_if_instr = valid ? instr_mem_q[rd_ptr_q] : last_instr_q;
  assign bus.o_q_count  = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_q == CW'(DEPTH))))
    else $error("if_fetch_queue: push into full queue");

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed stimulus, expected head PCs queued in a scoreboard
// and compared by a monitor on every accepted pop.
module tb_if_fetch_queue;
  localparam int XLEN  = 64;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_fetch_queue_if #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) bus ();

  if_fetch_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [XLEN-1:0] exp_q[$];
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;

  function automatic logic [ILEN-1:0] enc(input logic [XLEN-1:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A00_0013;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction memory: answers one cycle after the request with address-encoded data.
  initial begin
    bus.i_im_rdata = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      mem_req  = bus.o_im_req;
      mem_addr = bus.o_im_addr;
      @(posedge clk);
      #1;
      bus.i_im_rdata = mem_req ? enc(mem_addr) : 32'hDEAD_BEEF;
    end
  end

  // Monitor: every accepted head must match the next expected PC.
  initial begin
    logic [XLEN-1:0] p;
    forever begin
      @(negedge clk);
      if (rst_n && bus.o_if_valid && bus.i_id_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_pop", bus.o_if_pc, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          p = exp_q.pop_front();
          check("sb_pc", bus.o_if_pc, p);
          check("sb_instr", 64'(bus.o_if_instr), 64'(enc(p)));
        end
      end
    end
  end

  task automatic do_redirect(input logic ex, input logic [63:0] ex_t,
                             input logic id, input logic [63:0] id_t,
                             input logic [63:0] exp_a, input logic [63:0] exp_n,
                             input string tag);
    bus.i_ex_redirect = ex;
    bus.i_ex_target   = ex_t;
    bus.i_id_redirect = id;
    bus.i_id_target   = id_t;
    @(negedge clk);
    check({tag, "_req"}, 64'(bus.o_im_req), 64'd1);
    check({tag, "_addr"}, bus.o_im_addr, exp_a);
    tick();
    bus.i_ex_redirect = 1'b0;
    bus.i_id_redirect = 1'b0;
    @(negedge clk);
    check({tag, "_flush_count"}, 64'(bus.o_q_count), 64'd0);
    check({tag, "_next_addr"}, bus.o_im_addr, exp_n);
    tick();
    @(negedge clk);
    check({tag, "_valid_n2"}, 64'(bus.o_if_valid), 64'd1);
    check({tag, "_pc_n2"}, bus.o_if_pc, exp_a);
    tick();
    tick();
    exp_q.push_back(exp_a);
    exp_q.push_back(exp_n);
    bus.i_id_ready = 1'b1;
    tick();
    tick();
    bus.i_id_ready = 1'b0;
  endtask

  initial begin
    bus.i_ex_redirect = 1'b0;
    bus.i_ex_target   = '0;
    bus.i_id_redirect = 1'b0;
    bus.i_id_target   = '0;
    bus.i_id_ready    = 1'b0;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    check("rst_valid", 64'(bus.o_if_valid), 64'd0);
    check("rst_count", 64'(bus.o_q_count), 64'd0);
    check("rst_req", 64'(bus.o_im_req), 64'd0);
    check("rst_instr", 64'(bus.o_if_instr), 64'd0);
    check("rst_pc", bus.o_if_pc, 64'd0);

    // Stalled ID: queue fills to DEPTH, fetch stops at 0x10
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    check("stall_count", 64'(bus.o_q_count), 64'd4);
    check("stall_req", 64'(bus.o_im_req), 64'd0);
    check("stall_addr", bus.o_im_addr, 64'h10);
    check("stall_head_pc", bus.o_if_pc, 64'h0);
    for (int i = 0; i < 8; i++) exp_q.push_back(64'(4 * i));
    tick();
    bus.i_id_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("drain_no_gap", 64'(bus.o_if_valid), 64'd1);
      tick();
    end
    bus.i_id_ready = 1'b0;
    check("pre_redirect_count", 64'(bus.o_q_count), 64'd3);

    // EX redirect with 3 queued and one in flight
    do_redirect(1'b1, 64'h100, 1'b0, 64'h0, 64'h100, 64'h104, "ex");
    // EX and ID together: EX wins
    do_redirect(1'b1, 64'h200, 1'b1, 64'h300, 64'h200, 64'h204, "prio");
    // Misaligned ID target
    do_redirect(1'b0, 64'h0, 1'b1, 64'h403, 64'h400, 64'h404, "id_align");
    // Fetch PC wrap at the top of the address space
    do_redirect(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0,
                64'hFFFF_FFFF_FFFF_FFFC, 64'h0, "wrap");

    // Reset mid-stream with a full queue
    repeat (4) tick();
    check("full_before_rst", 64'(bus.o_q_count), 64'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(bus.o_if_valid), 64'd0);
    check("midrst_count", 64'(bus.o_q_count), 64'd0);
    check("midrst_req", 64'(bus.o_im_req), 64'd0);
    tick();
    tick();

    // Release with ID always ready: one instruction per cycle from cycle 2
    for (int i = 0; i < 8; i++) exp_q.push_back(64'(4 * i));
    bus.i_id_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stream_req", 64'(bus.o_im_req), 64'd1);
      check("stream_addr", bus.o_im_addr, 64'(4 * i));
      if (i < 2) check("stream_latency_valid", 64'(bus.o_if_valid), 64'd0);
      tick();
    end
    bus.i_id_ready = 1'b0;
    repeat (3) tick();
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
